// File: rtl/force_deposit_pkg.sv
// Shared types for the override register bank: command opcodes and the queued command record.
// Struct field widths follow the bank's default geometry.
package force_deposit_pkg;

  localparam int unsigned OvrNumRegs = 4;
  localparam int unsigned OvrDw      = 4;
  localparam int unsigned OvrAw      = $clog2(OvrNumRegs);

  typedef enum logic [2:0] {
    NOP      = 3'd0,
    DEPOSIT  = 3'd1,
    ASSIGN   = 3'd2,
    DEASSIGN = 3'd3,
    FORCE    = 3'd4,
    RELEASE  = 3'd5
  } ovr_op_e;

  typedef struct packed {
    ovr_op_e            op;
    logic [OvrAw-1:0]   addr;
    logic [OvrDw-1:0]   data;
  } ovr_cmd_t;

endpackage

// File: rtl/force_deposit_reg_bank_fifo.sv
// Synchronous command FIFO; a push is accepted while full if a pop happens in the same cycle.
module ovr_cmd_fifo
  import force_deposit_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  ovr_cmd_t data_i,
  input  logic     pop_i,
  output ovr_cmd_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  ovr_cmd_t        mem_q [Depth];
  logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/force_deposit_reg_bank.sv
// Register bank applying queued deposit/assign/force commands on top of a functional write port.
// Reads return the effective value with precedence force > assign > stored.
module force_deposit_reg_bank
  import force_deposit_pkg::*;
#(
  parameter int unsigned NUM_REGS   = OvrNumRegs,
  parameter int unsigned DW         = OvrDw,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                func_we,
  input  logic [AW-1:0]       func_addr,
  input  logic [DW-1:0]       func_wdata,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [AW-1:0]       cmd_addr,
  input  logic [DW-1:0]       cmd_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic [NUM_REGS-1:0] forced_mask,
  output logic [NUM_REGS-1:0] assigned_mask,
  output logic                cmd_err,
  output logic                busy
);

  ovr_cmd_t push_cmd, head_cmd;
  logic     fifo_full, fifo_empty, push, pop;

  assign push_cmd  = '{op: ovr_op_e'(cmd_op), addr: cmd_addr, data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !fifo_empty;
  assign busy      = !fifo_empty;

  ovr_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (push_cmd),
    .pop_i   (pop),
    .data_o  (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  logic [DW-1:0]       stored_q  [NUM_REGS];
  logic [DW-1:0]       stored_d  [NUM_REGS];
  logic [DW-1:0]       asg_val_q [NUM_REGS];
  logic [DW-1:0]       asg_val_d [NUM_REGS];
  logic [DW-1:0]       frc_val_q [NUM_REGS];
  logic [DW-1:0]       frc_val_d [NUM_REGS];
  logic [NUM_REGS-1:0] asg_on_q, asg_on_d;
  logic [NUM_REGS-1:0] frc_on_q, frc_on_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic                cmd_err_q, cmd_err_d;
  logic                head_err;

  always_comb begin
    head_err = 1'b0;
    if (32'(head_cmd.addr) >= NUM_REGS) begin
      head_err = 1'b1;
    end else begin
      case (head_cmd.op)
        NOP, DEPOSIT, ASSIGN, FORCE: head_err = 1'b0;
        DEASSIGN:                    head_err = !asg_on_q[head_cmd.addr];
        RELEASE:                     head_err = !frc_on_q[head_cmd.addr];
        default:                     head_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    stored_d  = stored_q;
    asg_val_d = asg_val_q;
    frc_val_d = frc_val_q;
    asg_on_d  = asg_on_q;
    frc_on_d  = frc_on_q;

    if (func_we && (32'(func_addr) < NUM_REGS) && !asg_on_q[func_addr]) begin
      stored_d[func_addr] = func_wdata;
    end

    // Applied after the functional write so a same-address command wins.
    if (pop && !head_err) begin
      case (head_cmd.op)
        DEPOSIT: stored_d[head_cmd.addr] = head_cmd.data;
        ASSIGN: begin
          asg_val_d[head_cmd.addr] = head_cmd.data;
          asg_on_d[head_cmd.addr]  = 1'b1;
        end
        DEASSIGN: begin
          stored_d[head_cmd.addr] = asg_val_q[head_cmd.addr];
          asg_on_d[head_cmd.addr] = 1'b0;
        end
        FORCE: begin
          frc_val_d[head_cmd.addr] = head_cmd.data;
          frc_on_d[head_cmd.addr]  = 1'b1;
        end
        RELEASE: begin
          frc_on_d[head_cmd.addr] = 1'b0;
          if (!asg_on_q[head_cmd.addr]) stored_d[head_cmd.addr] = frc_val_q[head_cmd.addr];
        end
        default: ;
      endcase
    end

    cmd_err_d = pop && head_err;

    rd_data_d = '0;
    if (32'(rd_addr) < NUM_REGS) begin
      if (frc_on_q[rd_addr])      rd_data_d = frc_val_q[rd_addr];
      else if (asg_on_q[rd_addr]) rd_data_d = asg_val_q[rd_addr];
      else                        rd_data_d = stored_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        stored_q[i]  <= '0;
        asg_val_q[i] <= '0;
        frc_val_q[i] <= '0;
      end
      asg_on_q  <= '0;
      frc_on_q  <= '0;
      rd_data_q <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      stored_q  <= stored_d;
      asg_val_q <= asg_val_d;
      frc_val_q <= frc_val_d;
      asg_on_q  <= asg_on_d;
      frc_on_q  <= frc_on_d;
      rd_data_q <= rd_data_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign cmd_err       = cmd_err_q;
  assign forced_mask   = frc_on_q;
  assign assigned_mask = asg_on_q;

endmodule
